// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: the CPU stores bytes into TXDATA, which feeds a TX FIFO and a
// serialiser. The CPU reads STATUS back through a registered read port that sits beside the data RAM.
module mmio_uart_tx #(
  parameter int unsigned     XLEN       = 32,
  parameter logic [XLEN-1:0] BASE_ADDR  = XLEN'(32'h0001_0000),
  parameter int unsigned     FIFO_DEPTH = 16,
  parameter int unsigned     CLK_DIV    = 104
) (
  input  logic            clk_i,
  input  logic            rst_n_i,
  input  logic [XLEN-1:0] dram_wr_addr_i,
  input  logic [XLEN-1:0] dram_wr_data_i,
  input  logic [3:0]      dram_wr_byte_en_i,
  input  logic [XLEN-1:0] dram_rd_addr_i,
  output logic            mmio_rd_sel_o,
  output logic [XLEN-1:0] mmio_rd_data_o,
  output logic            uart_tx_o,
  output logic            tx_busy_o
);

  localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned DivW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DivW-1:0] DivMax = DivW'(CLK_DIV - 1);
  localparam logic [CntW-1:0] Depth  = CntW'(FIFO_DEPTH);

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

  state_e            state_q, state_d;
  logic [DivW-1:0]   div_q, div_d;
  logic [2:0]        bit_q, bit_d;
  logic [7:0]        shift_q, shift_d;
  logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]   count_q, count_d;
  logic              ovf_q, ovf_d;
  logic              rd_sel_q;
  logic [XLEN-1:0]   rd_data_q, status;
  logic [7:0]        mem_q [FIFO_DEPTH];

  logic wr_hit, rd_hit, push_req, clr_req, push, pop, full, empty;
  logic [8:0] count_ext;

  assign wr_hit   = dram_wr_addr_i[XLEN-1:3] == BASE_ADDR[XLEN-1:3];
  assign rd_hit   = dram_rd_addr_i[XLEN-1:3] == BASE_ADDR[XLEN-1:3];
  assign push_req = wr_hit && !dram_wr_addr_i[2] && dram_wr_byte_en_i[0];
  assign clr_req  = wr_hit && dram_wr_addr_i[2] && dram_wr_byte_en_i[0] && dram_wr_data_i[3];
  assign full     = count_q == Depth;
  assign empty    = count_q == '0;
  // Full is judged on pre-pop occupancy, so a push while full drops even if a pop happens.
  assign push     = push_req && !full;

  logic unused_bits;
  assign unused_bits = ^{dram_wr_data_i[XLEN-1:8], dram_wr_addr_i[1:0], dram_rd_addr_i[1:0],
                         dram_wr_byte_en_i[3:1]};

  assign count_ext = 9'(count_q);

  always_comb begin
    status        = '0;
    status[0]     = full;
    status[1]     = empty;
    status[2]     = state_q != StIdle;
    status[3]     = ovf_q;
    status[15:8]  = count_ext[7:0];
  end

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    pop     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!empty) begin
          pop     = 1'b1;
          shift_d = mem_q[rd_ptr_q];
          div_d   = '0;
          state_d = StStart;
        end
      end
      StStart: begin
        if (div_q == DivMax) begin
          div_d   = '0;
          bit_d   = '0;
          state_d = StData;
        end else begin
          div_d = div_q + DivW'(1);
        end
      end
      StData: begin
        if (div_q == DivMax) begin
          div_d   = '0;
          shift_d = shift_q >> 1;
          if (bit_q == 3'd7) state_d = StStop;
          else               bit_d   = bit_q + 3'd1;
        end else begin
          div_d = div_q + DivW'(1);
        end
      end
      StStop: begin
        if (div_q == DivMax) begin
          div_d   = '0;
          state_d = StIdle;
        end else begin
          div_d = div_q + DivW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + PtrW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PtrW'(1) : rd_ptr_q;
    count_d  = count_q;
    if (push && !pop)      count_d = count_q + CntW'(1);
    else if (!push && pop) count_d = count_q - CntW'(1);
    ovf_d = ovf_q;
    if (push_req && full) ovf_d = 1'b1;
    else if (clr_req)     ovf_d = 1'b0;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q   <= StIdle;
      div_q     <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      ovf_q     <= 1'b0;
      rd_sel_q  <= 1'b0;
      rd_data_q <= '0;
    end else begin
      state_q   <= state_d;
      div_q     <= div_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      ovf_q     <= ovf_d;
      rd_sel_q  <= rd_hit;
      rd_data_q <= (rd_hit && dram_rd_addr_i[2]) ? status : '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= dram_wr_data_i[7:0];
  end

  always_comb begin
    uart_tx_o = 1'b1;
    unique case (state_q)
      StStart: uart_tx_o = 1'b0;
      StData:  uart_tx_o = shift_q[0];
      default: uart_tx_o = 1'b1;
    endcase
  end

  assign tx_busy_o      = !empty || (state_q != StIdle);
  assign mmio_rd_sel_o  = rd_sel_q;
  assign mmio_rd_data_o = rd_data_q;

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Bench for mmio_uart_tx: a byte-queue/frame-time model is checked every cycle, alongside directed
// scenarios with literal expectations and a line-level serial decoder.
module tb_mmio_uart_tx;
  localparam int unsigned D     = 4;
  localparam int unsigned DEPTH = 16;
  localparam logic [31:0] BASE  = 32'h0001_0000;
  localparam logic [31:0] IDLEA = 32'h0000_1000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] wr_addr = IDLEA, wr_data = '0, rd_addr = IDLEA;
  logic [3:0]  wr_be = '0;
  logic        rd_sel, tx, busy;
  logic [31:0] rd_data;

  int errs = 0;
  int checks = 0;

  mmio_uart_tx #(
    .XLEN(32), .BASE_ADDR(BASE), .FIFO_DEPTH(DEPTH), .CLK_DIV(D)
  ) dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .dram_wr_addr_i(wr_addr), .dram_wr_data_i(wr_data), .dram_wr_byte_en_i(wr_be),
    .dram_rd_addr_i(rd_addr),
    .mmio_rd_sel_o(rd_sel), .mmio_rd_data_o(rd_data),
    .uart_tx_o(tx), .tx_busy_o(busy)
  );

  initial forever #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: FIFO as a byte queue, shifter as "cycles into frame" (-1 when idle).
  logic [7:0]  mq[$];
  logic        movf;
  int          mt;
  logic [7:0]  mcur;
  logic        msel;
  logic [31:0] mdata;

  function automatic logic [31:0] model_status();
    logic [31:0] s;
    s       = '0;
    s[0]    = mq.size() == DEPTH;
    s[1]    = mq.size() == 0;
    s[2]    = mt >= 0;
    s[3]    = movf;
    s[15:8] = 8'(mq.size());
    return s;
  endfunction

  function automatic logic model_tx();
    int k;
    if (mt < 0) return 1'b1;
    k = mt / D;
    if (k == 0) return 1'b0;
    if (k == 9) return 1'b1;
    return mcur[k-1];
  endfunction

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      mq.delete(); movf = 0; mt = -1; mcur = '0; msel = 0; mdata = '0;
    end else begin
      logic full_p, active_p, do_pop, rh, wh;
      logic [31:0] st;
      full_p   = mq.size() == DEPTH;
      active_p = mt >= 0;
      st       = model_status();
      rh       = (rd_addr >> 3) == (BASE >> 3);
      msel     = rh;
      mdata    = (rh && rd_addr[2]) ? st : 32'h0;
      do_pop   = !active_p && mq.size() > 0;
      if (active_p) begin
        mt++;
        if (mt == 10 * D) mt = -1;
      end
      if (do_pop) begin
        mcur = mq.pop_front();
        mt   = 0;
      end
      wh = (wr_addr >> 3) == (BASE >> 3);
      if (wh && wr_be[0]) begin
        if (!wr_addr[2]) begin
          if (full_p) movf = 1'b1;
          else        mq.push_back(wr_data[7:0]);
        end else if (wr_data[3]) begin
          movf = 1'b0;
        end
      end
    end
  end

  initial forever begin
    @(negedge clk);
    chk("tx_vs_model", {31'b0, tx}, {31'b0, model_tx()});
    chk("busy_vs_model", {31'b0, busy}, {31'b0, (mq.size() > 0) || (mt >= 0)});
    chk("rd_sel_vs_model", {31'b0, rd_sel}, {31'b0, msel});
    chk("rd_data_vs_model", rd_data, mdata);
  end

  // Serial line decoder sampling mid-bit.
  logic [7:0] rx_q[$];
  initial begin
    int rx_t;
    int k;
    logic [7:0] rx_b;
    rx_t = -1;
    rx_b = '0;
    forever begin
      @(negedge clk or negedge rst_n);
      if (!rst_n) rx_t = -1;
      else begin
        if (rx_t < 0 && !tx) rx_t = 0;
        else if (rx_t >= 0) rx_t++;
        if (rx_t >= 0 && (rx_t % D) == D / 2) begin
          k = rx_t / D;
          if (k >= 1 && k <= 8) rx_b[k-1] = tx;
          if (k == 9) begin
            rx_q.push_back(rx_b);
            rx_t = -1;
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    wr_addr = a; wr_data = d; wr_be = be;
    step();
    wr_be = '0; wr_addr = IDLEA;
  endtask

  task automatic load_chk(input string name, input logic [31:0] a, input logic [31:0] exp);
    rd_addr = a;
    step();
    rd_addr = IDLEA;
    @(negedge clk);
    chk({name, "_sel"}, {31'b0, rd_sel}, 32'h1);
    chk(name, rd_data, exp);
    step();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    logic [9:0] exp_bits;
    do_reset();

    // Idle after reset, then STATUS and TXDATA loads.
    repeat (50) step();
    rd_addr = BASE + 32'd4;
    @(negedge clk);
    chk("rd_sel_not_early", {31'b0, rd_sel}, 32'h0);
    step();
    rd_addr = IDLEA;
    @(negedge clk);
    chk("rd_sel_reset_status", {31'b0, rd_sel}, 32'h1);
    chk("reset_status", rd_data, 32'h0000_0002);
    step();
    load_chk("txdata_reads_zero", BASE, 32'h0);

    // Single 0x55 frame, literal bit-by-bit timing.
    rx_q.delete();
    exp_bits = 10'h2AA;
    store(BASE, 32'h0000_0055, 4'b0001);
    @(negedge clk);
    chk("tx_high_1_after", {31'b0, tx}, 32'h1);
    @(negedge clk);
    chk("tx_low_2_after", {31'b0, tx}, 32'h0);
    for (int j = 0; j < 10; j++) begin
      repeat ((j == 0) ? 1 : 4) @(negedge clk);
      chk($sformatf("frame55_bit%0d", j), {31'b0, tx}, {31'b0, exp_bits[j]});
    end
    repeat (2) @(negedge clk);
    chk("busy_last_stop_cycle", {31'b0, busy}, 32'h1);
    @(negedge clk);
    chk("busy_drop_after_40", {31'b0, busy}, 32'h0);
    chk("rx55_count", rx_q.size(), 32'd1);
    if (rx_q.size() > 0) chk("rx55_byte", {24'b0, rx_q[0]}, 32'h55);
    step();

    // Back-to-back 'A','B','C'.
    rx_q.delete();
    store(BASE, 32'h41, 4'b0001);
    store(BASE, 32'h42, 4'b0001);
    store(BASE, 32'h43, 4'b0001);
    load_chk("abc_status", BASE + 32'd4, 32'h0000_0204);
    repeat (140) step();
    chk("abc_rx_count", rx_q.size(), 32'd3);
    if (rx_q.size() == 3) begin
      chk("abc_rx0", {24'b0, rx_q[0]}, 32'h41);
      chk("abc_rx1", {24'b0, rx_q[1]}, 32'h42);
      chk("abc_rx2", {24'b0, rx_q[2]}, 32'h43);
    end

    // Overflow: one byte in flight, then 17 pushes while it shifts; the last is dropped.
    store(BASE, 32'h00, 4'b0001);
    for (int i = 1; i <= 17; i++) store(BASE, i, 4'b0001);
    load_chk("ovf_status", BASE + 32'd4, 32'h0000_100D);
    store(BASE + 32'd4, 32'h8, 4'b0001);
    load_chk("ovf_cleared", BASE + 32'd4, 32'h0000_1005);
    do_reset();

    // Ignored stores: wrong byte lane, address outside the window.
    rx_q.delete();
    store(BASE, 32'h77, 4'b0010);
    store(BASE + 32'd8, 32'h77, 4'b0001);
    load_chk("ignored_status", BASE + 32'd4, 32'h0000_0002);
    repeat (20) step();
    chk("ignored_no_frame", rx_q.size(), 32'd0);

    // Same-cycle store and load: the load sees pre-store state.
    wr_addr = BASE; wr_data = 32'h5A; wr_be = 4'b0001; rd_addr = BASE + 32'd4;
    step();
    wr_be = '0; wr_addr = IDLEA; rd_addr = IDLEA;
    @(negedge clk);
    chk("same_cycle_status", rd_data, 32'h0000_0002);
    step();
    do_reset();

    // Reset during DATA bit 3 of a 0x00 frame.
    rx_q.delete();
    store(BASE, 32'h00, 4'b0001);
    repeat (18) @(posedge clk);
    @(negedge clk);
    chk("bit3_low", {31'b0, tx}, 32'h0);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_tx_high", {31'b0, tx}, 32'h1);
    chk("async_rst_not_busy", {31'b0, busy}, 32'h0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    load_chk("post_rst_status", BASE + 32'd4, 32'h0000_0002);
    repeat (60) step();
    chk("post_rst_no_frame", rx_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
